// File: rtl/wb_regfile.sv
// Write-back register file: GPRs plus HI/LO, with same-cycle write-to-read bypass.
// Optional debug port and commit counter enabled by defining REGFILE_DBG_EN.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              wb_we_hilo,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
`ifdef REGFILE_DBG_EN
    ,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [31:0]       dbg_wr_cnt
`endif
);

    localparam logic [ADDR_W:0] NREGS_C = (ADDR_W + 1)'(NREGS);

    // Address names a real, writable register (not r0, not beyond NREGS).
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && ({1'b0, a} < NREGS_C);
    endfunction

    logic [DATA_W-1:0] gpr [NREGS];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              gpr_wr;

    assign gpr_wr = wb_we && addr_ok(wb_waddr);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                gpr[i] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (gpr_wr) begin
                gpr[wb_waddr] <= wb_wdata;
            end
            if (wb_we_hilo) begin
                hi_q <= wb_hi;
                lo_q <= wb_lo;
            end
        end
    end

    // Bypass only matters for valid addresses, so it sits below the address checks.
    assign rdata1 = (rst || !re1 || !addr_ok(raddr1)) ? '0 :
                    (wb_we && (wb_waddr == raddr1))   ? wb_wdata : gpr[raddr1];

    assign rdata2 = (rst || !re2 || !addr_ok(raddr2)) ? '0 :
                    (wb_we && (wb_waddr == raddr2))   ? wb_wdata : gpr[raddr2];

    assign hi = rst ? '0 : (wb_we_hilo ? wb_hi : hi_q);
    assign lo = rst ? '0 : (wb_we_hilo ? wb_lo : lo_q);

`ifdef REGFILE_DBG_EN
    logic [31:0] wr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q <= '0;
        end else if (gpr_wr) begin
            wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end

    // Committed state only: no bypass, so the observer sees what is really stored.
    assign dbg_data   = (rst || !addr_ok(dbg_addr)) ? '0 : gpr[dbg_addr];
    assign dbg_wr_cnt = wr_cnt_q;
`endif

endmodule
